// File: rtl/mii_q_mem_if_if.sv
// Bundles the Q-datapath <-> Q-table BRAM signals; master = datapath, slave = memory interface.
interface mii_q_mem_if_if #(
  parameter int L_WIDTH    = 4,
  parameter int Q_WIDTH    = 16,
  parameter int ADDR_WIDTH = 32
);
  localparam int N_LEVEL   = 2 ** (L_WIDTH / 2);
  localparam int S_WIDTH   = 2 * L_WIDTH;
  localparam int D_WIDTH   = Q_WIDTH * N_LEVEL;
  localparam int WEN_WIDTH = D_WIDTH / 8;
  localparam int A_WIDTH   = 2 + L_WIDTH / 2;

  logic [A_WIDTH-1:0]    A;
  logic [S_WIDTH-1:0]    S;
  logic [Q_WIDTH-1:0]    Q_new;
  logic [D_WIDTH-1:0]    D_road0;
  logic [D_WIDTH-1:0]    D_road1;
  logic [D_WIDTH-1:0]    D_road2;
  logic [D_WIDTH-1:0]    D_road3;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [D_WIDTH-1:0]    D_new;
  logic [WEN_WIDTH-1:0]  wen_bram0;
  logic [WEN_WIDTH-1:0]  wen_bram1;
  logic [WEN_WIDTH-1:0]  wen_bram2;
  logic [WEN_WIDTH-1:0]  wen_bram3;
  logic [D_WIDTH-1:0]    DEBUG_D;
  logic [1:0]            DEBUG_Ar;

  modport master (
    output A, S, Q_new, D_road0, D_road1, D_road2, D_road3, wen,
    input  rd_addr, wr_addr, D_new, wen_bram0, wen_bram1, wen_bram2, wen_bram3,
           DEBUG_D, DEBUG_Ar
  );

  modport slave (
    input  A, S, Q_new, D_road0, D_road1, D_road2, D_road3, wen,
    output rd_addr, wr_addr, D_new, wen_bram0, wen_bram1, wen_bram2, wen_bram3,
           DEBUG_D, DEBUG_Ar
  );
endinterface

// File: rtl/mii_q_mem_if.sv
// Q-table memory interface: row addressing, lane merge of Q_new, per-road byte-enable write.
// Read address/debug are combinational; write path is 1 clk; no backpressure, a request every cycle.
module mii_q_mem_if #(
  parameter int L_WIDTH    = 4,
  parameter int Q_WIDTH    = 16,
  parameter int R_WIDTH    = 16,
  parameter int ADDR_WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mii_q_mem_if_if.slave bus
);
  localparam int N_LEVEL   = 2 ** (L_WIDTH / 2);
  localparam int S_WIDTH   = 2 * L_WIDTH;
  localparam int D_WIDTH   = Q_WIDTH * N_LEVEL;
  localparam int WEN_WIDTH = D_WIDTH / 8;
  localparam int EN_WIDTH  = WEN_WIDTH / N_LEVEL;
  localparam int A_WIDTH   = 2 + L_WIDTH / 2;
  localparam int D_SEL_W   = L_WIDTH / 2;
  localparam int ROW_SHIFT = $clog2(WEN_WIDTH);

  // The reward is consumed upstream; its width is only kept for parameter compatibility.
  if (R_WIDTH < 1) begin : g_r_width_invalid
  end

  logic [1:0]            a_r;
  logic [D_SEL_W-1:0]    a_d;
  logic [D_WIDTH-1:0]    d_road [4];
  logic [D_WIDTH-1:0]    d_sel;
  logic [D_WIDTH-1:0]    d_merge;
  logic [WEN_WIDTH-1:0]  lane_en;
  logic [ADDR_WIDTH-1:0] row_addr;

  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [D_WIDTH-1:0]    d_new_q;
  logic [WEN_WIDTH-1:0]  wen_q [4];

  assign a_r = bus.A[A_WIDTH-1 -: 2];
  assign a_d = bus.A[D_SEL_W-1:0];

  assign d_road[0] = bus.D_road0;
  assign d_road[1] = bus.D_road1;
  assign d_road[2] = bus.D_road2;
  assign d_road[3] = bus.D_road3;
  assign d_sel     = d_road[a_r];

  // Row S starts at byte S*WEN_WIDTH; the zero pad keeps the top row from wrapping.
  assign row_addr = {{(ADDR_WIDTH - S_WIDTH - ROW_SHIFT){1'b0}}, bus.S, {ROW_SHIFT{1'b0}}};

  always_comb begin
    d_merge = d_sel;
    lane_en = '0;
    for (int k = 0; k < N_LEVEL; k++) begin
      if (a_d == D_SEL_W'(k)) begin
        d_merge[k*Q_WIDTH +: Q_WIDTH]  = bus.Q_new;
        lane_en[k*EN_WIDTH +: EN_WIDTH] = {EN_WIDTH{1'b1}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q <= '0;
      d_new_q   <= '0;
      for (int r = 0; r < 4; r++) begin
        wen_q[r] <= '0;
      end
    end else begin
      wr_addr_q <= row_addr;
      d_new_q   <= d_merge;
      for (int r = 0; r < 4; r++) begin
        wen_q[r] <= (bus.wen && (a_r == 2'(r))) ? lane_en : '0;
      end
    end
  end

  assign bus.rd_addr   = row_addr;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.D_new     = d_new_q;
  assign bus.wen_bram0 = wen_q[0];
  assign bus.wen_bram1 = wen_q[1];
  assign bus.wen_bram2 = wen_q[2];
  assign bus.wen_bram3 = wen_q[3];
  assign bus.DEBUG_D   = d_sel;
  assign bus.DEBUG_Ar  = a_r;
endmodule

// File: tb/tb_mii_q_mem_if.sv
// Directed and random stimulus for mii_q_mem_if; expected write results queued per request.
module tb_mii_q_mem_if;
  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] d;
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [7:0]  w2;
    logic [7:0]  w3;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  mii_q_mem_if_if bus ();

  mii_q_mem_if dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] s, input logic [15:0] q,
                       input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                       input logic [63:0] d3, input logic we);
    bus.A = a; bus.S = s; bus.Q_new = q;
    bus.D_road0 = d0; bus.D_road1 = d1; bus.D_road2 = d2; bus.D_road3 = d3;
    bus.wen = we;
  endtask

  // Reference: rebuild the word bit by bit and the enables byte by byte.
  function automatic exp_t model(input logic r);
    exp_t        e;
    logic [63:0] src;
    logic [7:0]  w;
    e = '0;
    if (r) return e;
    case (bus.A[3:2])
      2'd0:    src = bus.D_road0;
      2'd1:    src = bus.D_road1;
      2'd2:    src = bus.D_road2;
      default: src = bus.D_road3;
    endcase
    e.addr = 32'(bus.S) * 32'd8;
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 16; b++)
        e.d[k*16+b] = (k == int'(bus.A[1:0])) ? bus.Q_new[b] : src[k*16+b];
    for (int b = 0; b < 8; b++)
      w[b] = bus.wen && ((b / 2) == int'(bus.A[1:0]));
    e.w0 = (bus.A[3:2] == 2'd0) ? w : 8'h00;
    e.w1 = (bus.A[3:2] == 2'd1) ? w : 8'h00;
    e.w2 = (bus.A[3:2] == 2'd2) ? w : 8'h00;
    e.w3 = (bus.A[3:2] == 2'd3) ? w : 8'h00;
    return e;
  endfunction

  // Queue the expectation, clock once, then compare the registered outputs 1 unit after the edge.
  task automatic step(input exp_t e, input string tag);
    exp_t got;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      got = sb_q.pop_front();
      chk({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'(got.addr));
      chk({tag, "_D_new"}, bus.D_new, got.d);
      chk({tag, "_wen0"}, 64'(bus.wen_bram0), 64'(got.w0));
      chk({tag, "_wen1"}, 64'(bus.wen_bram1), 64'(got.w1));
      chk({tag, "_wen2"}, 64'(bus.wen_bram2), 64'(got.w2));
      chk({tag, "_wen3"}, 64'(bus.wen_bram3), 64'(got.w3));
    end
  endtask

  initial begin
    exp_t        e;
    logic [63:0] dsel;

    // Reset held 5 clocks with random inputs and write requests.
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(4'($urandom), 8'($urandom), 16'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      step('0, "reset");
    end
    rst = 1'b0;

    // Combinational read address, including the top row.
    bus.S = 8'h5A; #1;
    chk("rd_addr_5A", 64'(bus.rd_addr), 64'h0000_02D0);
    bus.S = 8'hFF; #1;
    chk("rd_addr_FF", 64'(bus.rd_addr), 64'h0000_07F8);

    // Road 2, lane 1 write.
    drive(4'b10_01, 8'h03, 16'hBEEF, 64'h0, 64'h0, 64'h4444_3333_2222_1111, 64'h0, 1'b1);
    e = '{addr: 32'h18, d: 64'h4444_3333_BEEF_1111, w0: 8'h00, w1: 8'h00, w2: 8'b0000_1100, w3: 8'h00};
    step(e, "write_r2");

    // Top lane of road 0 at the highest row.
    drive(4'b00_11, 8'hFF, 16'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h2, 1'b1);
    e = '{addr: 32'h7F8, d: 64'h1234_0000_0000_0000, w0: 8'hC0, w1: 8'h00, w2: 8'h00, w3: 8'h00};
    step(e, "top_lane");

    // No write request: data still merges, no enables.
    drive(4'b01_10, 8'h10, 16'hCAFE, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 64'h0, 1'b0);
    e = '{addr: 32'h80, d: 64'hAAAA_CAFE_CCCC_DDDD, w0: 8'h00, w1: 8'h00, w2: 8'h00, w3: 8'h00};
    step(e, "no_wen");

    // Request during reset is dropped.
    rst = 1'b1;
    drive(4'b11_00, 8'h22, 16'h5555, 64'h1, 64'h2, 64'h3, 64'h4, 1'b1);
    step('0, "rst_drop");
    rst = 1'b0;

    // First edge after reset loads normally.
    drive(4'b11_00, 8'h01, 16'h0F0F, 64'h0, 64'h0, 64'h0, 64'h9999_8888_7777_6666, 1'b1);
    #1;
    chk("debug_ar", 64'(bus.DEBUG_Ar), 64'd3);
    chk("debug_d", bus.DEBUG_D, 64'h9999_8888_7777_6666);
    e = '{addr: 32'h8, d: 64'h9999_8888_7777_0F0F, w0: 8'h00, w1: 8'h00, w2: 8'h00, w3: 8'h03};
    step(e, "post_rst");

    // Random back-to-back requests with occasional reset.
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 19) == 0);
      drive(4'($urandom), 8'($urandom), 16'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 3) != 0));
      #1;
      case (bus.A[3:2])
        2'd0:    dsel = bus.D_road0;
        2'd1:    dsel = bus.D_road1;
        2'd2:    dsel = bus.D_road2;
        default: dsel = bus.D_road3;
      endcase
      chk("rnd_rd_addr", 64'(bus.rd_addr), 64'(bus.S) * 64'd8);
      chk("rnd_debug_ar", 64'(bus.DEBUG_Ar), 64'(bus.A[3:2]));
      chk("rnd_debug_d", bus.DEBUG_D, dsel);
      step(model(rst), "rnd");
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
